// File: rtl/p4_router_ing_sched_pkg.sv
// Shared types and the round-robin pick helper for the ingress scheduler.
package p4_router_ing_sched_pkg;

    localparam int unsigned MAX_PORTS = 32;
    localparam int unsigned PICK_W    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // First requester at or after ptr, wrapping at n; returns ptr when none request.
    function automatic int unsigned rr_pick(input logic [MAX_PORTS-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned       pick;
        logic              found;
        logic [PICK_W-1:0] idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            if (i < n && !found) begin
                if (ptr + i >= n) idx = PICK_W'(ptr + i - n);
                else              idx = PICK_W'(ptr + i);
                if (req[idx]) begin
                    pick  = int'(idx);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/p4_router_rr_arb.sv
// Combinational round-robin next-grant from a request vector and a priority pointer.
module p4_router_rr_arb
    import p4_router_ing_sched_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic [PORT_W-1:0]    grant,
    output logic                 valid
);

    always_comb begin
        grant = PORT_W'(rr_pick(MAX_PORTS'(req), 32'(ptr), NUM_PORTS));
        valid = |req;
    end

endmodule

// File: rtl/p4_router_ing_sched.sv
// Packet-granular round-robin ingress scheduler with MTU truncate-and-drain.
// Optional P4_ROUTER_ING_SCHED_PRIO0_EN: port 0 gets strict priority over the round-robin ports.
module p4_router_ing_sched
    import p4_router_ing_sched_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned MTU_BYTES  = 9600,
    parameter int unsigned PORT_W     = $clog2(NUM_PORTS)
) (
    input  logic                              clk,
    input  logic                              arstn,
    input  logic                              enable,
    input  logic [NUM_PORTS*DATA_BYTES*8-1:0] s_tdata,
    input  logic [NUM_PORTS*DATA_BYTES-1:0]   s_tkeep,
    input  logic [NUM_PORTS-1:0]              s_tlast,
    input  logic [NUM_PORTS-1:0]              s_tvalid,
    output logic [NUM_PORTS-1:0]              s_tready,
    output logic [DATA_BYTES*8-1:0]           m_tdata,
    output logic [DATA_BYTES-1:0]             m_tkeep,
    output logic                              m_tlast,
    output logic [PORT_W-1:0]                 m_tuser,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic                              m_sof,
    output logic                              trunc_err
);

    localparam int unsigned DW        = DATA_BYTES * 8;
    localparam int unsigned MAX_BEATS = (MTU_BYTES + DATA_BYTES - 1) / DATA_BYTES;
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);

    sched_state_t         state, state_nxt;
    logic [PORT_W-1:0]    grant, rr_ptr, arb_grant, idle_grant, next_ptr;
    logic [NUM_PORTS-1:0] arb_req;
    logic                 arb_valid, idle_req, ptr_adv;
    logic [CNT_W-1:0]     beat_cnt;
    logic [DW-1:0]        sel_data;
    logic [DATA_BYTES-1:0] sel_keep;
    logic                 sel_last, sel_valid, accept, at_max, busy_acc, drain_acc;

    p4_router_rr_arb #(.NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W)) u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

`ifdef P4_ROUTER_ING_SCHED_PRIO0_EN
    // Port 0 bypasses the arbiter and never moves the pointer.
    assign arb_req    = s_tvalid & ~NUM_PORTS'(1);
    assign idle_grant = s_tvalid[0] ? '0 : arb_grant;
    assign idle_req   = s_tvalid[0] || arb_valid;
    assign ptr_adv    = (grant != '0);
`else
    assign arb_req    = s_tvalid;
    assign idle_grant = arb_grant;
    assign idle_req   = arb_valid;
    assign ptr_adv    = 1'b1;
`endif

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant == PORT_W'(i)) begin
                sel_data  = s_tdata[i*DW +: DW];
                sel_keep  = s_tkeep[i*DATA_BYTES +: DATA_BYTES];
                sel_last  = s_tlast[i];
                sel_valid = s_tvalid[i];
            end
        end
    end

    assign accept    = sel_valid && (|s_tready);
    assign at_max    = (beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign busy_acc  = (state == BUSY) && accept;
    assign drain_acc = (state == DRAIN) && accept;
    assign next_ptr  = (grant == PORT_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && idle_req) state_nxt = BUSY;
            BUSY:    if (accept) begin
                         if (sel_last)    state_nxt = IDLE;
                         else if (at_max) state_nxt = DRAIN;
                     end
            DRAIN:   if (accept && sel_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_tready = '0;
        case (state)
            BUSY:    s_tready[grant] = !m_tvalid || m_tready;
            DRAIN:   s_tready[grant] = 1'b1;
            default: s_tready = '0;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            grant     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            m_tdata   <= '0;
            m_tkeep   <= '0;
            m_tlast   <= 1'b0;
            m_tuser   <= '0;
            m_tvalid  <= 1'b0;
            m_sof     <= 1'b0;
            trunc_err <= 1'b0;
        end else begin
            trunc_err <= busy_acc && at_max && !sel_last;
            if (state == IDLE && enable && idle_req) grant <= idle_grant;
            if (busy_acc) beat_cnt <= (sel_last || at_max) ? '0 : beat_cnt + 1'b1;
            if ((busy_acc || drain_acc) && sel_last && ptr_adv) rr_ptr <= next_ptr;
            if (busy_acc) begin
                m_tdata  <= sel_data;
                m_tkeep  <= sel_keep;
                m_tlast  <= sel_last || at_max;
                m_tuser  <= grant;
                m_sof    <= (beat_cnt == '0);
                m_tvalid <= 1'b1;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
                m_sof    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_p4_router_ing_sched.sv
// Scoreboard bench for p4_router_ing_sched (4 ports, 8-byte beats, 5-beat MTU).
module tb_p4_router_ing_sched;

    localparam int unsigned NP   = 4;
    localparam int unsigned DB   = 8;
    localparam int unsigned MTU  = 40;
    localparam int unsigned MAXB = 5;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } in_beat_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [1:0]  user;
        logic        sof;
    } out_beat_t;

    logic            clk, arstn, enable;
    logic [NP*DB*8-1:0] s_tdata;
    logic [NP*DB-1:0]   s_tkeep;
    logic [NP-1:0]   s_tlast, s_tvalid, s_tready;
    logic [63:0]     m_tdata;
    logic [7:0]      m_tkeep;
    logic            m_tlast, m_tvalid, m_tready, m_sof, trunc_err;
    logic [1:0]      m_tuser;

    in_beat_t    pq[NP][$];
    out_beat_t   exp_q[$];
    int unsigned acc2[$];
    int unsigned n_vec, n_err, cyc, out_cnt, trunc_cnt, base;
    logic        multi_rdy, bp, stall_prev, held_last;
    logic [63:0] held_data;

    p4_router_ing_sched #(.NUM_PORTS(NP), .DATA_BYTES(DB), .MTU_BYTES(MTU)) dut (
        .clk(clk), .arstn(arstn), .enable(enable),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_sof(m_sof), .trunc_err(trunc_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic add_pkt(input int unsigned port, input int unsigned nb, input int unsigned id);
        in_beat_t  ib;
        out_beat_t ob;
        for (int unsigned b = 0; b < nb; b++) begin
            ib.data = {8'(port), 8'(id), 16'(b), 32'($urandom)};
            ib.keep = (b == nb - 1) ? 8'h0F : 8'hFF;
            ib.last = (b == nb - 1);
            pq[port].push_back(ib);
            if (b < MAXB) begin
                ob.data = ib.data;
                ob.keep = ib.keep;
                ob.last = ib.last || (b == MAXB - 1);
                ob.user = 2'(port);
                ob.sof  = (b == 0);
                exp_q.push_back(ob);
            end
        end
    endtask

    function automatic int unsigned pending_in();
        int unsigned s = 0;
        for (int unsigned i = 0; i < NP; i++) s += pq[i].size();
        return s;
    endfunction

    task automatic wait_done(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || pending_in() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(exp_q.size() + pending_in()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_sof", m_sof, 0);
        chk("rst_trunc", trunc_err, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tuser", m_tuser, 0);
    endtask

    // Drive inputs on the falling edge, sample handshakes just before the rising edge.
    initial begin
        out_beat_t e;
        forever begin
            @(negedge clk);
            m_tready = bp ? ~m_tready : 1'b1;
            for (int unsigned i = 0; i < NP; i++) begin
                if (pq[i].size() != 0) begin
                    s_tvalid[i]          = 1'b1;
                    s_tdata[i*64 +: 64]  = pq[i][0].data;
                    s_tkeep[i*8 +: 8]    = pq[i][0].keep;
                    s_tlast[i]           = pq[i][0].last;
                end else begin
                    s_tvalid[i]          = 1'b0;
                    s_tdata[i*64 +: 64]  = '0;
                    s_tkeep[i*8 +: 8]    = '0;
                    s_tlast[i]           = 1'b0;
                end
            end
            #4;
            cyc++;
            if (!$onehot0(s_tready)) multi_rdy = 1'b1;
            for (int unsigned i = 0; i < NP; i++) begin
                if (s_tvalid[i] && s_tready[i]) begin
                    pq[i].delete(0);
                    if (i == 2) acc2.push_back(cyc);
                end
            end
            if (stall_prev && arstn) begin
                chk("hold_vld", m_tvalid, 1);
                chk("hold_data", m_tdata, held_data);
                chk("hold_last", m_tlast, held_last);
            end
            stall_prev = m_tvalid && !m_tready;
            held_data  = m_tdata;
            held_last  = m_tlast;
            if (m_tvalid && m_tready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", m_tdata, e.data);
                    chk("keep", m_tkeep, e.keep);
                    chk("last", m_tlast, e.last);
                    chk("user", m_tuser, e.user);
                    chk("sof", m_sof, e.sof);
                end
            end
            if (trunc_err) trunc_cnt++;
        end
    end

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; out_cnt = 0; trunc_cnt = 0;
        multi_rdy = 1'b0; bp = 1'b0; stall_prev = 1'b0;
        held_data = '0; held_last = 1'b0;
        arstn = 1'b0; enable = 1'b1; m_tready = 1'b1;
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        #2 arstn = 1'b1;

        // All four ports, 3-beat packets: served 0,1,2,3
        base = out_cnt;
        for (int unsigned p = 0; p < NP; p++) add_pkt(p, 3, p);
        wait_done("rr4_done", 300);
        chk("rr4_beats", 64'(out_cnt - base), 64'd12);

        // Single requester on port 2: one input-side bubble between packets
        acc2.delete();
        add_pkt(2, 1, 10);
        add_pkt(2, 1, 11);
        wait_done("p2_done", 100);
        chk("p2_accepts", 64'(acc2.size()), 64'd2);
        if (acc2.size() == 2) chk("p2_bubble", 64'(acc2[1] - acc2[0]), 64'd2);

        // 7-beat packet on port 1 truncated to 5, then port 2
        trunc_cnt = 0;
        add_pkt(1, 7, 20);
        add_pkt(2, 1, 21);
        wait_done("trunc_done", 200);
        chk("trunc_pulses", 64'(trunc_cnt), 64'd1);
        chk("trunc_drained", 64'(pq[1].size()), 64'd0);

        // Exactly-MTU packet under toggling backpressure: no truncation
        bp = 1'b1;
        add_pkt(0, 5, 30);
        wait_done("bp_done", 200);
        bp = 1'b0;
        chk("bp_no_trunc", 64'(trunc_cnt), 64'd1);

        // Reset mid-packet, then ports 0 and 3 compete from a cleared pointer
        base = out_cnt;
        add_pkt(2, 4, 40);
        for (int unsigned n = 0; n < 100 && out_cnt < base + 2; n++) @(negedge clk);
        chk("rst_mid_beats", 64'(out_cnt - base), 64'd2);
        @(negedge clk);
        #2;
        arstn = 1'b0;
        pq[2].delete();
        exp_q.delete();
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        #2 arstn = 1'b1;
        add_pkt(0, 2, 50);
        add_pkt(3, 2, 51);
        wait_done("post_rst_done", 100);

        // Ports 0 and 1 request continuously
`ifdef P4_ROUTER_ING_SCHED_PRIO0_EN
        for (int unsigned k = 0; k < 3; k++) add_pkt(0, 1, 60 + k);
        for (int unsigned k = 0; k < 3; k++) add_pkt(1, 1, 70 + k);
`else
        for (int unsigned k = 0; k < 3; k++) begin
            add_pkt(0, 1, 60 + k);
            add_pkt(1, 1, 70 + k);
        end
`endif
        wait_done("prio_done", 200);

        chk("tready_onehot0", multi_rdy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
